btn_debounce: RTL
=================

BTN_DEBOUNCE -- requirements
Module: btn_debounce

Interface
REQ-001 SHALL have parameter DEBOUNCE_CYCLES, default 50000, meaning cycles of stable level required to accept a transition (5 ms at 10 MHz).
REQ-002 SHALL have parameter LONG_PRESS_CYCLES, default 20000000, meaning cycles held pressed before a long-press event (2 s at 10 MHz).
REQ-003 SHALL have port clk  input  1  clock; all logic on rising edge.
REQ-004 SHALL have port rst_n  input  1  reset, synchronous, active-low.
REQ-005 SHALL have port btn_n_raw  input  1  asynchronous raw button, active-low (0 = pressed).
REQ-006 SHALL have port btn_pressed  output  1  debounced level, 1 = pressed.
REQ-007 SHALL have port press_pulse  output  1  single-cycle strobe on accepted press.
REQ-008 SHALL have port release_pulse  output  1  single-cycle strobe on accepted release.
REQ-009 SHALL have port long_press_pulse  output  1  single-cycle strobe when a hold reaches LONG_PRESS_CYCLES.

Function
REQ-010 SHALL pass btn_n_raw through a 2-flop synchronizer; the debounce FSM sees only the second-flop output (sync_n).
REQ-011 SHALL implement FSM states UP, DB_DOWN, HELD, DB_UP with a debounce counter sized $clog2(DEBOUNCE_CYCLES).
REQ-012 UP: sync_n=0 -> DB_DOWN, counter cleared to 0; else stay.
REQ-013 DB_DOWN: sync_n=1 -> UP (bounce rejected, no pulse); sync_n=0 and counter==DEBOUNCE_CYCLES-1 -> HELD with press_pulse=1 for that one cycle; else counter+1.
REQ-014 HELD: sync_n=1 -> DB_UP, counter cleared; else stay.
REQ-015 DB_UP: sync_n=0 -> HELD (bounce rejected, no pulse); sync_n=1 and counter==DEBOUNCE_CYCLES-1 -> UP with release_pulse=1 for one cycle; else counter+1.
REQ-016 btn_pressed SHALL be 1 exactly while FSM is HELD or DB_UP.
REQ-017 Latency: if edge E0 first samples btn_n_raw=0 and it stays 0, press_pulse SHALL be high in the cycle after edge E0+DEBOUNCE_CYCLES+2; release symmetric.
REQ-018 Long-press counter SHALL clear on entry to HELD from DB_DOWN, increment each cycle in HELD or DB_UP, saturate at LONG_PRESS_CYCLES-1.
REQ-019 long_press_pulse SHALL assert for one cycle when the long-press counter reaches LONG_PRESS_CYCLES-1; at most once per accepted press.
REQ-020 A DB_UP->HELD bounce SHALL NOT clear the long-press counter nor re-arm long_press_pulse.
REQ-021 press_pulse, release_pulse, long_press_pulse SHALL be registered outputs and never assert in the same cycle as each other, except press/long cannot coincide because LONG_PRESS_CYCLES > DEBOUNCE_CYCLES.
REQ-022 Parameters SHALL satisfy DEBOUNCE_CYCLES >= 2 and LONG_PRESS_CYCLES > DEBOUNCE_CYCLES; elaboration-time check fails otherwise.

Reset
REQ-023 With rst_n=0 at a clock edge: synchronizer flops = 1, FSM = UP, all counters = 0, all outputs = 0.
REQ-024 Reset asserted mid-debounce or mid-hold SHALL abort with no pulse; after release of reset a still-held button SHALL be re-debounced and produce press_pulse per REQ-017.

Configuration
REQ-025 Macro BTN_LONG_PRESS_EN defined: long-press counter and REQ-018..020 present.
REQ-026 BTN_LONG_PRESS_EN undefined: long-press counter not instantiated, long_press_pulse tied 0, all other behaviour identical.

Structure
REQ-027 Shared package tt_game_pkg SHALL hold btn_state_t enum (UP, DB_DOWN, HELD, DB_UP) and default constants BTN_DEBOUNCE_CYCLES and BTN_LONG_PRESS_CYCLES.
REQ-028 Synchronizer SHALL be a separate sub-module btn_sync (2-flop, reset value 1); debounce FSM and counters live in btn_debounce.

Verification (DEBOUNCE_CYCLES=4, LONG_PRESS_CYCLES=20, BTN_LONG_PRESS_EN defined unless noted)
REQ-029 Clean press: btn_n_raw 1->0 sampled at edge 10 -> press_pulse high only in cycle after edge 16, btn_pressed=1 from then.
REQ-030 Bounce: btn_n_raw low 3 cycles then high -> no press_pulse, btn_pressed stays 0, FSM returns to UP.
REQ-031 Release with bounce: held, btn_n_raw high 2 cycles, low 1, high 10 -> exactly one release_pulse, btn_pressed falls with it.
REQ-032 Long hold: held 40 cycles after press_pulse -> exactly one long_press_pulse, 19 cycles after press_pulse; none with BTN_LONG_PRESS_EN undefined.
REQ-033 Reset mid-hold: rst_n=0 for 2 cycles while held -> all outputs 0, then press_pulse re-issued 6 cycles after reset release.

Source files
------------

// File: rtl/tt_game_pkg.sv
// Shared types and default timing constants for the game board's input logic.
// Defaults assume a 10 MHz clk: 5 ms debounce and 2 s long-press.
package tt_game_pkg;

  typedef enum logic [1:0] {
    UP      = 2'd0,
    DB_DOWN = 2'd1,
    HELD    = 2'd2,
    DB_UP   = 2'd3
  } btn_state_t;

  localparam int BTN_DEBOUNCE_CYCLES   = 50000;
  localparam int BTN_LONG_PRESS_CYCLES = 20000000;

endpackage

// File: rtl/btn_sync.sv
// Two-flop synchronizer for an active-low asynchronous input; resets to the idle level (1).
// Output lags the raw pin by two clk edges.
module btn_sync (
  input  logic clk,
  input  logic rst_n,
  input  logic din_n,
  output logic dout_n
);

  logic meta_n;

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      meta_n <= 1'b1;
      dout_n <= 1'b1;
    end else begin
      meta_n <= din_n;
      dout_n <= meta_n;
    end
  end

endmodule

// File: rtl/btn_debounce.sv
// Push-button debouncer with press/release strobes and optional long-press strobe.
// Long-press logic is built only when BTN_LONG_PRESS_EN is defined.
module btn_debounce
  import tt_game_pkg::*;
#(
  parameter int DEBOUNCE_CYCLES   = BTN_DEBOUNCE_CYCLES,
  parameter int LONG_PRESS_CYCLES = BTN_LONG_PRESS_CYCLES
) (
  input  logic clk,
  input  logic rst_n,
  input  logic btn_n_raw,
  output logic btn_pressed,
  output logic press_pulse,
  output logic release_pulse,
  output logic long_press_pulse
);

  localparam int DW = $clog2(DEBOUNCE_CYCLES);
  localparam logic [DW-1:0] DB_LAST = DW'(DEBOUNCE_CYCLES - 1);

  generate
    if (DEBOUNCE_CYCLES < 2 || LONG_PRESS_CYCLES <= DEBOUNCE_CYCLES) begin : g_bad_params
      $error("btn_debounce: need DEBOUNCE_CYCLES >= 2 and LONG_PRESS_CYCLES > DEBOUNCE_CYCLES");
    end
  endgenerate

  logic          sync_n;
  btn_state_t    state;
  logic [DW-1:0] cnt;
  logic          press_ev;
  logic          release_ev;

  btn_sync u_sync (
    .clk    (clk),
    .rst_n  (rst_n),
    .din_n  (btn_n_raw),
    .dout_n (sync_n)
  );

  assign press_ev   = (state == DB_DOWN) && !sync_n && (cnt == DB_LAST);
  assign release_ev = (state == DB_UP)   &&  sync_n && (cnt == DB_LAST);

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state         <= UP;
      cnt           <= '0;
      btn_pressed   <= 1'b0;
      press_pulse   <= 1'b0;
      release_pulse <= 1'b0;
    end else begin
      press_pulse   <= press_ev;
      release_pulse <= release_ev;
      case (state)
        UP: begin
          if (!sync_n) begin
            state <= DB_DOWN;
            cnt   <= '0;
          end
        end
        DB_DOWN: begin
          if (sync_n) begin
            state <= UP;
          end else if (cnt == DB_LAST) begin
            state       <= HELD;
            btn_pressed <= 1'b1;
          end else begin
            cnt <= cnt + 1'b1;
          end
        end
        HELD: begin
          if (sync_n) begin
            state <= DB_UP;
            cnt   <= '0;
          end
        end
        DB_UP: begin
          // A low sample here is a release bounce; the button is still considered held.
          if (!sync_n) begin
            state <= HELD;
          end else if (cnt == DB_LAST) begin
            state       <= UP;
            btn_pressed <= 1'b0;
          end else begin
            cnt <= cnt + 1'b1;
          end
        end
        default: state <= UP;
      endcase
    end
  end

`ifdef BTN_LONG_PRESS_EN
  localparam int LW = $clog2(LONG_PRESS_CYCLES);
  localparam logic [LW-1:0] LP_LAST = LW'(LONG_PRESS_CYCLES - 1);

  logic [LW-1:0] lp_cnt;
  logic          holding;

  assign holding = (state == HELD) || (state == DB_UP);

  // Cleared only by an accepted press, so release bounces cannot re-arm the strobe;
  // the strobe is dropped if it would land on the release cycle.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      lp_cnt           <= '0;
      long_press_pulse <= 1'b0;
    end else begin
      long_press_pulse <= 1'b0;
      if (press_ev) begin
        lp_cnt <= '0;
      end else if (holding && lp_cnt != LP_LAST) begin
        lp_cnt <= lp_cnt + 1'b1;
        if (lp_cnt == LP_LAST - 1'b1 && !release_ev)
          long_press_pulse <= 1'b1;
      end
    end
  end
`else
  assign long_press_pulse = 1'b0;
`endif

endmodule
